// File: rtl/mdrp_pkg.sv
// mdrp_pkg: shared encodings for the PLL MDRP responder.
// OPC codes, lock-relevant register addresses, lock FSM states.
package mdrp_pkg;

  localparam logic [1:0] MD_OPC_IDLE = 2'b00;
  localparam logic [1:0] MD_OPC_WR   = 2'b01;
  localparam logic [1:0] MD_OPC_RD   = 2'b10;
  localparam logic [1:0] MD_OPC_RSV  = 2'b11;

  localparam logic [7:0] MD_REG_ICP = 8'h0B;
  localparam logic [7:0] MD_REG_RES = 8'h11;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_WAIT = 2'd1,
    S_LOCK = 2'd2,
    S_FAIL = 2'd3
  } lock_state_t;

endpackage

// File: rtl/mdrp_lock_model.sv
// mdrp_lock_model: PLL relock timing model with settings check.
// i_pll_rst_s: synchronised PLL reset, i_good: settings ok,
// o_lock: registered lock, rises the cycle after S_LOCK entry.
module mdrp_lock_model
  import mdrp_pkg::*;
#(
  parameter int LOCK_DELAY = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pll_rst_s,
  input  logic i_good,
  output logic o_lock
);

  localparam int CW =
    (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(LOCK_DELAY - 1);

  lock_state_t   r_state;
  lock_state_t   w_next;
  logic [CW-1:0] r_cnt;
  logic          r_lock;
  logic          w_done;

  assign w_done = (r_cnt == CNT_LAST);
  assign o_lock = r_lock;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RST: begin
        if (!i_pll_rst_s) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_pll_rst_s)
          w_next = S_RST;
        else if (w_done)
          w_next = i_good ? S_LOCK : S_FAIL;
      end
      S_LOCK, S_FAIL: begin
        if (i_pll_rst_s) w_next = S_RST;
      end
      default: w_next = S_RST;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_next;
      // counter only runs while staying in S_WAIT
      if (r_state == S_WAIT && w_next == S_WAIT)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      r_lock <= (r_state == S_LOCK);
    end
  end

endmodule

// File: rtl/mdrp_pll_responder.sv
// mdrp_pll_responder: MDRP far-side regfile + PLL lock model.
// In: I_MD_CLK, I_RST (async high), I_PLL_RST, I_MD_INC,
// I_MD_OPC, I_MD_WR_DATA. Out: O_MD_RD_DATA, O_LOCK, O_ERR,
// O_ADDR. MDRP_ACCESS_CNT_EN adds O_WR_CNT / O_RD_CNT.
module mdrp_pll_responder
  import mdrp_pkg::*;
#(
  parameter int         DEPTH      = 32,
  parameter int         LOCK_DELAY = 64,
  parameter logic [2:0] GOOD_ICP   = 3'd1,
  parameter logic [2:0] GOOD_RES   = 3'd3
) (
  input  logic       I_MD_CLK,
  input  logic       I_RST,
  input  logic       I_PLL_RST,
  input  logic       I_MD_INC,
  input  logic [1:0] I_MD_OPC,
  input  logic [7:0] I_MD_WR_DATA,
  output logic [7:0] O_MD_RD_DATA,
  output logic       O_LOCK,
  output logic       O_ERR,
`ifdef MDRP_ACCESS_CNT_EN
  output logic [15:0] O_WR_CNT,
  output logic [15:0] O_RD_CNT,
`endif
  output logic [7:0] O_ADDR
);

  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  logic [7:0]    r_regs [DEPTH];
  logic [7:0]    r_ptr;
  logic [7:0]    r_rd_data;
  logic          r_pll_q;
  logic          r_err;
  logic          w_wr;
  logic          w_rd;
  logic          w_rsv;
  logic          w_clr;
  logic          w_in_rng;
  logic          w_err_evt;
  logic          w_good;
  logic [2:0]    w_icp;
  logic [2:0]    w_res;
  logic [AW-1:0] w_idx;

  always_comb begin
    w_wr  = 1'b0;
    w_rd  = 1'b0;
    w_rsv = 1'b0;
    unique case (I_MD_OPC)
      MD_OPC_WR:  w_wr  = 1'b1;
      MD_OPC_RD:  w_rd  = 1'b1;
      MD_OPC_RSV: w_rsv = 1'b1;
      default:    ;
    endcase
  end

  // falling edge of PLL reset = release; clears pointer
  assign w_clr    = r_pll_q & ~I_PLL_RST;
  assign w_in_rng = ({1'b0, r_ptr} < DEPTH9);
  assign w_idx    = r_ptr[AW-1:0];

  assign w_err_evt =
    w_rsv |
    (w_wr & ~I_PLL_RST) |
    ((I_MD_OPC != MD_OPC_IDLE) & w_clr);

  // lock settings; absent registers read as zero
  assign w_icp = (DEPTH > int'(MD_REG_ICP)) ?
    r_regs[MD_REG_ICP[AW-1:0]][2:0] : 3'd0;
  assign w_res = (DEPTH > int'(MD_REG_RES)) ?
    r_regs[MD_REG_RES[AW-1:0]][2:0] : 3'd0;
  assign w_good =
    (w_icp == GOOD_ICP) && (w_res == GOOD_RES);

  always_ff @(posedge I_MD_CLK or posedge I_RST) begin
    if (I_RST) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= 8'h00;
    end else if (w_wr && w_in_rng) begin
      r_regs[w_idx] <= I_MD_WR_DATA;
    end
  end

  always_ff @(posedge I_MD_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_ptr     <= 8'h00;
      r_rd_data <= 8'h00;
      r_pll_q   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pll_q <= I_PLL_RST;
      if (w_clr)
        r_ptr <= 8'h00;
      else if (I_MD_INC)
        r_ptr <= r_ptr + 8'd1;
      if (w_rd)
        r_rd_data <= w_in_rng ? r_regs[w_idx] : 8'h00;
      if (w_err_evt)
        r_err <= 1'b1;
    end
  end

`ifdef MDRP_ACCESS_CNT_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;

  always_ff @(posedge I_MD_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_wr_cnt <= 16'h0000;
      r_rd_cnt <= 16'h0000;
    end else begin
      if (w_wr && r_wr_cnt != 16'hFFFF)
        r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_rd && r_rd_cnt != 16'hFFFF)
        r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  assign O_WR_CNT = r_wr_cnt;
  assign O_RD_CNT = r_rd_cnt;
`endif

  mdrp_lock_model #(
    .LOCK_DELAY (LOCK_DELAY)
  ) u_lock (
    .i_clk       (I_MD_CLK),
    .i_rst       (I_RST),
    .i_pll_rst_s (r_pll_q),
    .i_good      (w_good),
    .o_lock      (O_LOCK)
  );

  assign O_MD_RD_DATA = r_rd_data;
  assign O_ERR        = r_err;
  assign O_ADDR       = r_ptr;

endmodule

// File: tb/tb_mdrp_pll_responder.sv
// tb_mdrp_pll_responder: vectors, hand sequences and random
// traffic against a behavioural MDRP model.
module tb_mdrp_pll_responder;

  localparam int DEPTH = 32;
  localparam int LD    = 64;

  logic       I_MD_CLK;
  logic       I_RST;
  logic       I_PLL_RST;
  logic       I_MD_INC;
  logic [1:0] I_MD_OPC;
  logic [7:0] I_MD_WR_DATA;
  logic [7:0] O_MD_RD_DATA;
  logic       O_LOCK;
  logic       O_ERR;
  logic [7:0] O_ADDR;
`ifdef MDRP_ACCESS_CNT_EN
  logic [15:0] O_WR_CNT;
  logic [15:0] O_RD_CNT;
`endif

  mdrp_pll_responder #(
    .DEPTH      (DEPTH),
    .LOCK_DELAY (LD),
    .GOOD_ICP   (3'd1),
    .GOOD_RES   (3'd3)
  ) dut (
    .I_MD_CLK     (I_MD_CLK),
    .I_RST        (I_RST),
    .I_PLL_RST    (I_PLL_RST),
    .I_MD_INC     (I_MD_INC),
    .I_MD_OPC     (I_MD_OPC),
    .I_MD_WR_DATA (I_MD_WR_DATA),
    .O_MD_RD_DATA (O_MD_RD_DATA),
    .O_LOCK       (O_LOCK),
    .O_ERR        (O_ERR),
`ifdef MDRP_ACCESS_CNT_EN
    .O_WR_CNT     (O_WR_CNT),
    .O_RD_CNT     (O_RD_CNT),
`endif
    .O_ADDR       (O_ADDR)
  );

  initial I_MD_CLK = 1'b0;
  always #5 I_MD_CLK = ~I_MD_CLK;

  int n_chk  = 0;
  int n_fail = 0;

  int m_mem [256];
  int m_ptr;
  int m_rd;
  int m_err;
  int m_pll_q;
  int m_wrc;
  int m_rdc;

  typedef struct {
    logic       inc;
    logic [1:0] opc;
    logic [7:0] wd;
    int         ea;
    int         erd;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string nm,
                       input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    m_ptr = 0; m_rd = 0; m_err = 0;
    m_pll_q = 0; m_wrc = 0; m_rdc = 0;
  endtask

  task automatic do_reset(input logic pll);
    I_RST = 1'b1;
    I_MD_INC = 1'b0;
    I_MD_OPC = 2'b00;
    I_MD_WR_DATA = 8'h00;
    I_PLL_RST = pll;
    #2;
    check("rst_addr", int'(O_ADDR), 0);
    check("rst_rd", int'(O_MD_RD_DATA), 0);
    check("rst_lock", int'(O_LOCK), 0);
    check("rst_err", int'(O_ERR), 0);
    @(posedge I_MD_CLK);
    #1;
    I_RST = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input logic inc, input logic [1:0] opc,
                     input logic [7:0] wd, input logic pll);
    int clr;
    I_MD_INC = inc;
    I_MD_OPC = opc;
    I_MD_WR_DATA = wd;
    I_PLL_RST = pll;
    @(posedge I_MD_CLK);
    #1;
    clr = (m_pll_q == 1 && pll == 1'b0) ? 1 : 0;
    if (opc == 2'd3 || (opc == 2'd1 && !pll) ||
        (opc != 2'd0 && clr == 1))
      m_err = 1;
    if (opc == 2'd1) begin
      m_wrc++;
      if (m_ptr < DEPTH) m_mem[m_ptr] = int'(wd);
    end
    if (opc == 2'd2) begin
      m_rdc++;
      m_rd = (m_ptr < DEPTH) ? m_mem[m_ptr] : 0;
    end
    if (clr == 1) m_ptr = 0;
    else if (inc) m_ptr = (m_ptr + 1) % 256;
    m_pll_q = pll ? 1 : 0;
    check("m_addr", int'(O_ADDR), m_ptr);
    check("m_rd", int'(O_MD_RD_DATA), m_rd);
    check("m_err", int'(O_ERR), m_err);
  endtask

  task automatic goto_addr(input int a);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b0, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < a; i++)
      cyc(1'b1, 2'd0, 8'h00, 1'b1);
    if (a == 0) cyc(1'b0, 2'd0, 8'h00, 1'b1);
  endtask

  task automatic wr_reg(input int a, input logic [7:0] d);
    goto_addr(a);
    cyc(1'b0, 2'd1, d, 1'b1);
  endtask

  task automatic rd_reg(input int a, input int exp,
                        input string nm);
    goto_addr(a);
    cyc(1'b0, 2'd2, 8'h00, 1'b1);
    check(nm, int'(O_MD_RD_DATA), exp);
  endtask

  // release PLL reset, check lock timing, then reassert
  task automatic relock(input int exp, input string nm);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    for (int i = 1; i <= LD + 3; i++) begin
      cyc(1'b0, 2'd0, 8'h00, 1'b0);
      if (i == 1)
        check({nm, "_ptr0"}, int'(O_ADDR), 0);
      if (i == LD + 1)
        check({nm, "_early"}, int'(O_LOCK), 0);
      if (i == LD + 3)
        check(nm, int'(O_LOCK), exp);
    end
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 2'd0, 8'h00, 1'b1);
    check({nm, "_drop"}, int'(O_LOCK), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 8'h00, 1, 0};
    tbl[1]  = '{1'b1, 2'd0, 8'h00, 2, 0};
    tbl[2]  = '{1'b1, 2'd0, 8'h00, 3, 0};
    tbl[3]  = '{1'b0, 2'd1, 8'hA5, 3, 0};
    tbl[4]  = '{1'b1, 2'd0, 8'h00, 4, 0};
    tbl[5]  = '{1'b0, 2'd2, 8'h00, 4, 0};
    tbl[6]  = '{1'b1, 2'd1, 8'h3C, 5, 0};
    tbl[7]  = '{1'b0, 2'd1, 8'h5A, 5, 0};
    tbl[8]  = '{1'b0, 2'd2, 8'h00, 5, 8'h5A};
    tbl[9]  = '{1'b1, 2'd2, 8'h00, 6, 8'h5A};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 6, 8'h5A};

    model_reset();
    do_reset(1'b1);

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].inc, tbl[i].opc, tbl[i].wd, 1'b1);
      check($sformatf("tbl%0d_addr", i),
            int'(O_ADDR), tbl[i].ea);
      check($sformatf("tbl%0d_rd", i),
            int'(O_MD_RD_DATA), tbl[i].erd);
    end

    rd_reg(3, 8'hA5, "reclear_rd3");
    rd_reg(4, 8'h3C, "rd4");

    wr_reg(8'h0B, 8'h01);
    wr_reg(8'h11, 8'h03);
    relock(1, "lock_good");

    wr_reg(8'h0B, 8'h02);
    relock(0, "lock_bad_icp");
    wr_reg(8'h0B, 8'h01);
    relock(1, "relock_good");

    goto_addr(0);
    for (int i = 0; i < 255; i++)
      cyc(1'b1, 2'd0, 8'h00, 1'b1);
    check("wrap_ff", int'(O_ADDR), 8'hFF);
    cyc(1'b1, 2'd0, 8'h00, 1'b1);
    check("wrap_00", int'(O_ADDR), 0);

    wr_reg(8, 8'h77);
    goto_addr(40);
    cyc(1'b0, 2'd1, 8'hEE, 1'b1);
    cyc(1'b0, 2'd2, 8'h00, 1'b1);
    check("rd_oor", int'(O_MD_RD_DATA), 0);
    rd_reg(8, 8'h77, "no_alias_rd8");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
      else
        cyc(1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)),
            8'($urandom), 1'b1);
    end

    cyc(1'b0, 2'd3, 8'h00, 1'b1);
    check("err_rsv", int'(O_ERR), 1);
    cyc(1'b0, 2'd0, 8'h00, 1'b0);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    check("err_sticky", int'(O_ERR), 1);
    do_reset(1'b1);
    cyc(1'b0, 2'd0, 8'h00, 1'b0);
    cyc(1'b0, 2'd1, 8'h11, 1'b0);
    check("err_wr_run", int'(O_ERR), 1);
    do_reset(1'b1);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b0, 2'd2, 8'h00, 1'b0);
    check("err_clr_opc", int'(O_ERR), 1);

    do_reset(1'b1);
    wr_reg(8'h0B, 8'h01);
    wr_reg(8'h11, 8'h03);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 2'd0, 8'h00, 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < LD + 4; i++)
      cyc(1'b0, 2'd0, 8'h00, 1'b0);
    check("abort_fail", int'(O_LOCK), 0);
    rd_reg(8'h0B, 0, "abort_icp0");
    rd_reg(8'h11, 0, "abort_res0");

`ifdef MDRP_ACCESS_CNT_EN
    check("wr_cnt", int'(O_WR_CNT), m_wrc);
    check("rd_cnt", int'(O_RD_CNT), m_rdc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdrp_pll_responder.md
Name: mdrp_pll_responder

Overview:
- Behavioural and synthesizable responder for the PLL MDRP (dynamic reconfiguration) port.
- Sits on the far side of the PLL init sequencer: it receives INC/OPC/WR_DATA and I_PLL_RST, returns RD_DATA and a modelled lock.
- Holds an 8-bit register file behind an auto-increment address pointer.
- Models PLL relock timing and a "good setting" window, so the sequencer's charge-pump/resistor sweep can be exercised in simulation and on hardware loopback.

Parameters:
- DEPTH, 32, number of implemented 8-bit registers (addresses 0..DEPTH-1); must be 16..256.
- LOCK_DELAY, 64, I_MD_CLK cycles from PLL reset release to lock evaluation.
- GOOD_ICP, 3'd1, value of reg[0x0B][2:0] required for lock.
- GOOD_RES, 3'd3, value of reg[0x11][2:0] required for lock.

Ports:
- I_MD_CLK  in  1  MDRP clock.
- I_RST  in  1  asynchronous, active-high reset.
- I_PLL_RST  in  1  PLL reset from the sequencer, active-high; the PLL is held in reset while high.
- I_MD_INC  in  1  address pointer increment strobe.
- I_MD_OPC  in  2  00 idle, 01 write, 10 read, 11 reserved.
- I_MD_WR_DATA  in  8  write data.
- O_MD_RD_DATA  out  8  registered read data.
- O_LOCK  out  1  modelled PLL lock.
- O_ERR  out  1  sticky protocol-error flag.
- O_ADDR  out  8  current address pointer (debug).

Behaviour:
- Reset (I_RST high, async): pointer=0, regfile all 0x00, O_MD_RD_DATA=0x00, O_LOCK=0, O_ERR=0, FSM=S_RST.
- Pointer:
  - 8-bit; increments by 1 on each clock with I_MD_INC=1; wraps 0xFF->0x00.
  - Clears to 0 on the clock after a detected falling edge of I_PLL_RST (reset release). This clear takes priority over INC.
- Access:
  - OPC is sampled each clock and uses the pointer value before any same-cycle INC.
  - Write (01): reg[ptr] <= I_MD_WR_DATA when ptr < DEPTH; dropped otherwise.
  - Read (10): O_MD_RD_DATA <= reg[ptr], or 0x00 if ptr >= DEPTH. Valid the cycle after OPC=10 and held until the next read.
  - Read-after-write to the same address on consecutive cycles returns the new data.
- O_ERR set, sticky until I_RST, when any of:
  - OPC=11;
  - OPC=01 while I_PLL_RST=0, i.e. a write while the PLL is running;
  - OPC!=00 together with a pointer clear in the same cycle.
- Lock FSM, with 1-cycle synchronised I_PLL_RST:
  - S_RST: O_LOCK=0, counter=0. On I_PLL_RST low -> S_WAIT.
  - S_WAIT: counter increments each cycle. I_PLL_RST high -> S_RST. counter==LOCK_DELAY-1 -> evaluate lock.
  - Lock evaluation: if reg[0x0B][2:0]==GOOD_ICP and reg[0x11][2:0]==GOOD_RES -> S_LOCK; else -> S_FAIL.
  - S_LOCK: O_LOCK=1 (registered; rises the cycle after entry). I_PLL_RST high -> S_RST, and O_LOCK falls the next cycle.
  - S_FAIL: O_LOCK=0. I_PLL_RST high -> S_RST.
- Register writes during S_LOCK (an error case) do not drop lock; only a PLL reset re-evaluates.
- I_RST mid-operation aborts everything at once: regfile cleared, FSM to S_RST.

Optional Feature:
- MDRP_ACCESS_CNT_EN defined:
  - Adds ports O_WR_CNT (16) and O_RD_CNT (16), counting accepted writes and reads (in-range and out-of-range alike).
  - Counters saturate at 0xFFFF and clear on I_RST only.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mdrp_pkg holds:
  - OPC encodings MD_OPC_IDLE/WR/RD/RSV;
  - register addresses MD_REG_ICP=8'h0B and MD_REG_RES=8'h11;
  - lock FSM state encodings.
- One sub-module, mdrp_lock_model: the lock FSM plus delay counter. Inputs are the synchronised PLL reset and a "settings good" bit; output is O_LOCK.

Test Plan:
- Reset, then INC×3 and write 0xA5, then INC and read -> reg[3]=0xA5, O_ADDR=4, O_MD_RD_DATA=0x00 (reg[4]); read at ptr 3 after pointer reclear and INC×3 returns 0xA5.
- Write reg[0x0B]=0x01 and reg[0x11]=0x03 with I_PLL_RST=1, then drop I_PLL_RST -> O_LOCK=1 exactly LOCK_DELAY+1..+2 cycles after release; pointer reads 0 one cycle after release.
- Same sequence with reg[0x0B]=0x02 -> O_LOCK stays 0 (S_FAIL); reassert and release with 0x01 -> lock.
- 255 INCs from 0 followed by 1 INC -> pointer 0xFF then 0x00; read at pointer 40 with DEPTH=32 -> 0x00; write at 40 leaves reg[8] unchanged.
- OPC=11, or a write while I_PLL_RST=0 -> O_ERR=1 next cycle and held through a subsequent PLL reset; cleared only by I_RST.
- Assert I_RST during S_WAIT -> O_LOCK=0 and regfile zero; after release with I_PLL_RST=0 the model waits in S_WAIT and enters S_FAIL because the regfile is zero.
